// File: rtl/excp_ctrl.sv
// -----------------------------------------------------------------------------
// excp_ctrl -- exception / ertn sequencing and CSR state for the writeback stage.
//
// An exception or ertn retiring in WB starts a three-phase sequence:
//   IDLE -> FLUSH (one-cycle flush pulse) -> REDIRECT (hold redirect until the
//   fetch stage accepts it) -> IDLE.
// While a sequence is active, busy holds WB allow-in low, so new events are
// stalled rather than lost.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   wb_valid/wb_excp/wb_ertn      writeback instruction qualifiers
//   wb_pc, wb_ecode, wb_esubcode  faulting pc and exception cause
//   eentry_we, eentry_wdata       software write of EENTRY (low 6 bits zeroed)
//   redirect_ready                fetch accepts the redirect this cycle
//   flush                         one-cycle pipeline flush pulse
//   redirect_valid, redirect_pc   fetch redirect request
//   busy                          a sequence is in progress
//   crmd_*, prmd_*, era, estat_*, eentry   current CSR values
// -----------------------------------------------------------------------------
module excp_ctrl #(
    parameter logic [31:0] RESET_EENTRY = 32'h1C00_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_excp,
    input  logic        wb_ertn,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic        eentry_we,
    input  logic [31:0] eentry_wdata,
    input  logic        redirect_ready,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [1:0]  crmd_plv,
    output logic        crmd_ie,
    output logic [1:0]  prmd_pplv,
    output logic        prmd_pie,
    output logic [31:0] era,
    output logic [5:0]  estat_ecode,
    output logic [8:0]  estat_esubcode,
    output logic [31:0] eentry
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] target_r;
    logic        flush_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;
    logic        busy_r;
    logic [1:0]  crmd_plv_r;
    logic        crmd_ie_r;
    logic [1:0]  prmd_pplv_r;
    logic        prmd_pie_r;
    logic [31:0] era_r;
    logic [5:0]  estat_ecode_r;
    logic [8:0]  estat_esubcode_r;
    logic [31:0] eentry_r;

    logic        ev_excp_s;
    logic        ev_ertn_s;

    // EENTRY is 64-byte aligned; the low write-data bits are deliberately dropped.
    logic        unused_eentry_low_s;
    assign unused_eentry_low_s = ^eentry_wdata[5:0];

    // Event decode: only sampled in IDLE; exception wins over ertn.
    always_comb begin
        ev_excp_s = 1'b0;
        ev_ertn_s = 1'b0;
        if ((state_r == ST_IDLE) && wb_valid) begin
            ev_excp_s = wb_excp;
            ev_ertn_s = (~wb_excp) & wb_ertn;
        end else begin
            ev_excp_s = 1'b0;
            ev_ertn_s = 1'b0;
        end
    end

    // Sequencer FSM, CSR updates and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            target_r         <= 32'h0000_0000;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'h0000_0000;
            busy_r           <= 1'b0;
            crmd_plv_r       <= 2'd0;
            crmd_ie_r        <= 1'b0;
            prmd_pplv_r      <= 2'd0;
            prmd_pie_r       <= 1'b0;
            era_r            <= 32'h0000_0000;
            estat_ecode_r    <= 6'd0;
            estat_esubcode_r <= 9'd0;
            eentry_r         <= RESET_EENTRY;
        end else begin
            // Software write is honoured in every state; the exception
            // capture below still reads the pre-write eentry_r.
            if (eentry_we) begin
                eentry_r <= {eentry_wdata[31:6], 6'b00_0000};
            end

            case (state_r)
                ST_IDLE: begin
                    if (ev_excp_s) begin
                        prmd_pplv_r      <= crmd_plv_r;
                        prmd_pie_r       <= crmd_ie_r;
                        crmd_plv_r       <= 2'd0;
                        crmd_ie_r        <= 1'b0;
                        era_r            <= wb_pc;
                        estat_ecode_r    <= wb_ecode;
                        estat_esubcode_r <= wb_esubcode;
                        target_r         <= eentry_r;
                        state_r          <= ST_FLUSH;
                        flush_r          <= 1'b1;
                        busy_r           <= 1'b1;
                    end else if (ev_ertn_s) begin
                        crmd_plv_r <= prmd_pplv_r;
                        crmd_ie_r  <= prmd_pie_r;
                        target_r   <= era_r;
                        state_r    <= ST_FLUSH;
                        flush_r    <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        flush_r          <= 1'b0;
                        redirect_valid_r <= 1'b0;
                        busy_r           <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state_r          <= ST_REDIRECT;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= target_r;
                    busy_r           <= 1'b1;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_r          <= ST_IDLE;
                        redirect_valid_r <= 1'b0;
                        busy_r           <= 1'b0;
                    end else begin
                        redirect_valid_r <= 1'b1;
                        busy_r           <= 1'b1;
                    end
                end
                default: begin
                    state_r          <= ST_IDLE;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    busy_r           <= 1'b0;
                end
            endcase
        end
    end

    assign flush          = flush_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign busy           = busy_r;
    assign crmd_plv       = crmd_plv_r;
    assign crmd_ie        = crmd_ie_r;
    assign prmd_pplv      = prmd_pplv_r;
    assign prmd_pie       = prmd_pie_r;
    assign era            = era_r;
    assign estat_ecode    = estat_ecode_r;
    assign estat_esubcode = estat_esubcode_r;
    assign eentry         = eentry_r;

endmodule

// File: doc/excp_ctrl.md
EXCP_CTRL -- requirements
Module: excp_ctrl

Interface
REQ-001 SHALL have parameter RESET_EENTRY, default 32'h1C00_8000, exception entry address used after reset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wb_valid  input  1  writeback stage holds a valid instruction.
REQ-005 SHALL have port wb_excp  input  1  writeback instruction raises an exception (syscall class).
REQ-006 SHALL have port wb_ertn  input  1  writeback instruction is ertn.
REQ-007 SHALL have port wb_pc  input  32  pc of writeback instruction.
REQ-008 SHALL have ports wb_ecode  input  6 and wb_esubcode  input  9  exception code and subcode.
REQ-009 SHALL have ports eentry_we  input  1 and eentry_wdata  input  32  software write of EENTRY (bits [5:0] forced 0).
REQ-010 SHALL have port redirect_ready  input  1  fetch stage accepts the redirect this cycle.
REQ-011 SHALL have port flush  output  1  pipeline flush pulse to IF/ID/EX/ME.
REQ-012 SHALL have ports redirect_valid  output  1 and redirect_pc  output  32  fetch redirect request.
REQ-013 SHALL have port busy  output  1  forces WB allow-in low while a sequence is active.
REQ-014 SHALL have outputs crmd_plv 2, crmd_ie 1, prmd_pplv 2, prmd_pie 1, era 32, estat_ecode 6, estat_esubcode 9, eentry 32 (current CSR values).

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH, REDIRECT; busy = (state != IDLE).
REQ-016 In IDLE, event = wb_valid & (wb_excp | wb_ertn); wb_excp has priority when both high (handled as exception).
REQ-017 On exception event in IDLE SHALL, same edge: prmd_pplv<=crmd_plv, prmd_pie<=crmd_ie, crmd_plv<=0, crmd_ie<=0, era<=wb_pc, estat_ecode<=wb_ecode, estat_esubcode<=wb_esubcode, target<=eentry, state<=FLUSH.
REQ-018 On ertn event in IDLE SHALL, same edge: crmd_plv<=prmd_pplv, crmd_ie<=prmd_pie, target<=era, state<=FLUSH; PRMD, ERA, ESTAT unchanged.
REQ-019 flush SHALL be 1 for exactly the one cycle state==FLUSH; FLUSH always goes to REDIRECT next edge.
REQ-020 In REDIRECT, redirect_valid=1 and redirect_pc=target, held stable until redirect_ready=1; on that edge state<=IDLE.
REQ-021 redirect_ready sampled only in REDIRECT; ignored otherwise.
REQ-022 Events arriving while busy SHALL be ignored (WB is stalled by busy, so none are lost).
REQ-023 Latency: event edge -> flush next cycle -> redirect_valid cycle after; minimum 3 cycles from event to return to IDLE.
REQ-024 eentry_we SHALL update eentry on any state, {eentry_wdata[31:6],6'b0}; if same edge as exception capture, target uses old eentry.
REQ-025 wb_valid=0 SHALL never start a sequence regardless of wb_excp/wb_ertn.

Reset
REQ-026 reset SHALL set state IDLE, flush 0, redirect_valid 0, redirect_pc 0, busy 0, target 0, crmd_plv 0, crmd_ie 0, prmd_pplv 0, prmd_pie 0, era 0, estat_ecode 0, estat_esubcode 0, eentry RESET_EENTRY.
REQ-027 reset asserted mid-sequence SHALL abort it; no redirect_valid the following cycle.

Verification
REQ-028 Syscall: plv=3, ie=1, wb_pc=0x1C00_0100, ecode=0x0B -> era=0x1C00_0100, pplv=3, pie=1, plv=0, ie=0; flush 1 cycle; redirect_pc=0x1C00_8000.
REQ-029 Ertn after REQ-028 -> plv=3, ie=1, redirect_pc=0x1C00_0100, ERA unchanged.
REQ-030 Redirect backpressure: redirect_ready low 4 cycles -> redirect_valid and redirect_pc stable 5 cycles, busy high throughout, IDLE after accept.
REQ-031 wb_excp and wb_ertn both high, wb_pc=0x40 -> exception path taken, era=0x40; wb_excp high with wb_valid=0 -> no change.
REQ-032 eentry_we with 0x1C00_9ABC -> eentry=0x1C00_9A80; following exception redirects to 0x1C00_9A80.
REQ-033 reset during REDIRECT -> next cycle redirect_valid=0, busy=0, all CSRs at reset values.
